// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the RV32I pipeline hazard control slice.
//   REG_ADDR_W   : architectural register address width
//   REG_X0       : address of the hard-wired zero register
//   pipe_entry_t : destination-register state carried by a shadow stage
//   BUBBLE       : empty stage (no instruction, no write)
//   make_entry() : builds an entry, dropping writes that target x0
// ----------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wren;
    logic                  is_load;
  } pipe_entry_t;

  localparam pipe_entry_t BUBBLE = '{valid: 1'b0, rd: '0, wren: 1'b0, is_load: 1'b0};

  // A write to x0 never produces a value anyone may forward or wait on, so
  // it is stored as a non-writing instruction.
  function automatic pipe_entry_t make_entry(input logic                  valid,
                                             input logic [REG_ADDR_W-1:0] rd,
                                             input logic                  wren,
                                             input logic                  is_load);
    pipe_entry_t e;
    e.valid   = valid;
    e.rd      = rd;
    e.wren    = wren & (rd != REG_X0);
    e.is_load = is_load;
    return e;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// ----------------------------------------------------------------------------
// hazard_stage_reg
// One shadow pipeline stage holding destination-register state.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears the valid bit
//   hold   : keep current contents (pipeline freeze)
//   bubble : load an empty stage instead of d
//   d      : incoming entry from the previous stage
//   q      : current entry
// Only the valid bit is reset; the payload is don't-care while valid is low
// and every consumer qualifies it with valid.
// ----------------------------------------------------------------------------
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        bubble,
  input  pipe_entry_t d,
  output pipe_entry_t q
);

  logic                  valid_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  wren_q;
  logic                  is_load_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (!hold) begin
      valid_q <= bubble ? BUBBLE.valid : d.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!hold) begin
      if (bubble) begin
        rd_q      <= BUBBLE.rd;
        wren_q    <= BUBBLE.wren;
        is_load_q <= BUBBLE.is_load;
      end else begin
        rd_q      <= d.rd;
        wren_q    <= d.wren;
        is_load_q <= d.is_load;
      end
    end
  end

  assign q = '{valid: valid_q, rd: rd_q, wren: wren_q, is_load: is_load_q};

endmodule

// File: rtl/hazard_control_unit.sv
// ----------------------------------------------------------------------------
// hazard_control_unit
// Producer-side hazard control for the RV32I 5-stage pipeline. Tracks the
// destination register of the instructions in EX, MEM and WB, generates
// load-use stalls / EX bubbles / memory-wait freezes, and feeds the operand
// forwarding unit with rd addresses and forward-allow qualifiers.
//
// Parameters
//   CNT_W        : width of the saturating load-use bubble counter
//   DMEM_TIMEOUT : consecutive freeze cycles before o_dmem_timeout sets (>=1)
//
// Ports
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_id_*                 : decoded fields of the instruction in ID
//   i_flush                : redirect resolved in EX, squash ID
//   i_dmem_ack             : load data valid in MEM this cycle
//   o_stall_id             : hold PC and IF/ID
//   o_bubble_ex            : inject NOP into ID/EX
//   o_freeze               : hold all pipeline registers
//   o_mem_rd_addr/_fwd_allow, o_wb_rd_addr/_fwd_allow : forwarding qualifiers
//   o_busy_vec             : registers with an in-flight write
//   o_load_use_cnt         : saturating count of load-use bubbles
//   o_dmem_timeout         : sticky memory-wait timeout flag
// ----------------------------------------------------------------------------
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DMEM_TIMEOUT = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
  input  logic                  i_id_rs1_valid,
  input  logic                  i_id_rs2_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rd_addr,
  input  logic                  i_id_rd_wren,
  input  logic                  i_id_is_load,
  input  logic                  i_flush,
  input  logic                  i_dmem_ack,
  output logic                  o_stall_id,
  output logic                  o_bubble_ex,
  output logic                  o_freeze,
  output logic [REG_ADDR_W-1:0] o_mem_rd_addr,
  output logic                  o_mem_fwd_allow,
  output logic [REG_ADDR_W-1:0] o_wb_rd_addr,
  output logic                  o_wb_fwd_allow,
  output logic [31:0]           o_busy_vec,
  output logic [CNT_W-1:0]      o_load_use_cnt,
  output logic                  o_dmem_timeout
);

  localparam int WAIT_W = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(DMEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DMEM_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
    return (v == WAIT_MAX) ? v : v + WAIT_W'(1);
  endfunction

  function automatic logic writes_reg(input pipe_entry_t e,
                                      input logic [REG_ADDR_W-1:0] r);
    return e.valid & e.wren & (e.rd == r);
  endfunction

  pipe_entry_t id_entry;
  pipe_entry_t ex_p0;
  pipe_entry_t mem_p1;
  pipe_entry_t wb_p2;
  logic        vld_p0;
  logic        vld_p1;
  logic        vld_p2;

  logic        rs1_hit;
  logic        rs2_hit;
  logic        load_use;
  logic        ex_bubble;

  logic [CNT_W-1:0]  lu_cnt_q;
  logic [WAIT_W-1:0] wait_q;
  logic              timeout_q;
  logic              timeout_hit;

  assign id_entry = make_entry(i_id_valid, i_id_rd_addr, i_id_rd_wren, i_id_is_load);

  assign vld_p0 = ex_p0.valid;
  assign vld_p1 = mem_p1.valid;
  assign vld_p2 = wb_p2.valid;

  // Hazard detection: a load in MEM without data freezes everything; a load
  // in EX whose rd is read by ID needs one bubble.
  assign o_freeze = vld_p1 & mem_p1.is_load & ~i_dmem_ack;

  assign rs1_hit  = i_id_rs1_valid & (i_id_rs1_addr == ex_p0.rd);
  assign rs2_hit  = i_id_rs2_valid & (i_id_rs2_addr == ex_p0.rd);
  assign load_use = i_id_valid & vld_p0 & ex_p0.is_load & ex_p0.wren & (rs1_hit | rs2_hit);

  // A redirect squashes the consumer, so there is nothing left to stall for.
  assign o_bubble_ex = load_use & ~o_freeze & ~i_flush;
  assign o_stall_id  = (load_use & ~i_flush) | o_freeze;

  // EX loads an empty slot on a flush or a load-use stall; while frozen the
  // hold input wins and the flush is simply seen again once the freeze clears.
  assign ex_bubble = i_flush | load_use;

  // ---- stage p0: EX ----
  hazard_stage_reg u_ex_stage (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .hold   (o_freeze),
    .bubble (ex_bubble),
    .d      (id_entry),
    .q      (ex_p0)
  );

  // ---- stage p1: MEM ----
  hazard_stage_reg u_mem_stage (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .hold   (o_freeze),
    .bubble (1'b0),
    .d      (ex_p0),
    .q      (mem_p1)
  );

  // ---- stage p2: WB ----
  hazard_stage_reg u_wb_stage (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .hold   (o_freeze),
    .bubble (1'b0),
    .d      (mem_p1),
    .q      (wb_p2)
  );

  // Forwarding qualifiers. A load in MEM is only forwardable in the cycle
  // its data is acknowledged.
  assign o_mem_rd_addr   = vld_p1 ? mem_p1.rd : REG_X0;
  assign o_wb_rd_addr    = vld_p2 ? wb_p2.rd  : REG_X0;
  assign o_mem_fwd_allow = vld_p1 & mem_p1.wren & (~mem_p1.is_load | i_dmem_ack);
  assign o_wb_fwd_allow  = vld_p2 & wb_p2.wren;

  // x0 entries never carry wren, so bit 0 is skipped outright.
  always_comb begin
    o_busy_vec = '0;
    for (int r = 1; r < 32; r++) begin
      o_busy_vec[r] = writes_reg(ex_p0,  REG_ADDR_W'(r)) |
                      writes_reg(mem_p1, REG_ADDR_W'(r)) |
                      writes_reg(wb_p2,  REG_ADDR_W'(r));
    end
  end

  // The flag is raised combinationally in the freeze cycle that completes the
  // timeout window so it is visible in that same cycle, then held sticky.
  assign timeout_hit = o_freeze & (wait_q >= WAIT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lu_cnt_q  <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (o_bubble_ex) begin
        lu_cnt_q <= sat_inc_cnt(lu_cnt_q);
      end
      wait_q <= o_freeze ? sat_inc_wait(wait_q) : '0;
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign o_load_use_cnt = lu_cnt_q;
  assign o_dmem_timeout = timeout_q | timeout_hit;

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  localparam int CNT_W   = 4;
  localparam int TMO     = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_id_valid;
  logic [4:0]       i_id_rs1_addr;
  logic [4:0]       i_id_rs2_addr;
  logic             i_id_rs1_valid;
  logic             i_id_rs2_valid;
  logic [4:0]       i_id_rd_addr;
  logic             i_id_rd_wren;
  logic             i_id_is_load;
  logic             i_flush;
  logic             i_dmem_ack;
  logic             o_stall_id;
  logic             o_bubble_ex;
  logic             o_freeze;
  logic [4:0]       o_mem_rd_addr;
  logic             o_mem_fwd_allow;
  logic [4:0]       o_wb_rd_addr;
  logic             o_wb_fwd_allow;
  logic [31:0]      o_busy_vec;
  logic [CNT_W-1:0] o_load_use_cnt;
  logic             o_dmem_timeout;

  hazard_control_unit #(.CNT_W(CNT_W), .DMEM_TIMEOUT(TMO)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_id_valid     (i_id_valid),
    .i_id_rs1_addr  (i_id_rs1_addr),
    .i_id_rs2_addr  (i_id_rs2_addr),
    .i_id_rs1_valid (i_id_rs1_valid),
    .i_id_rs2_valid (i_id_rs2_valid),
    .i_id_rd_addr   (i_id_rd_addr),
    .i_id_rd_wren   (i_id_rd_wren),
    .i_id_is_load   (i_id_is_load),
    .i_flush        (i_flush),
    .i_dmem_ack     (i_dmem_ack),
    .o_stall_id     (o_stall_id),
    .o_bubble_ex    (o_bubble_ex),
    .o_freeze       (o_freeze),
    .o_mem_rd_addr  (o_mem_rd_addr),
    .o_mem_fwd_allow(o_mem_fwd_allow),
    .o_wb_rd_addr   (o_wb_rd_addr),
    .o_wb_fwd_allow (o_wb_fwd_allow),
    .o_busy_vec     (o_busy_vec),
    .o_load_use_cnt (o_load_use_cnt),
    .o_dmem_timeout (o_dmem_timeout)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: in-flight instructions indexed 0=EX, 1=MEM, 2=WB.
  bit mv[3];
  int mrd[3];
  bit mwr[3];
  bit mld[3];
  int m_lu;
  int m_streak;
  bit m_tflag;

  bit          e_freeze, e_lu, e_bubble, e_stall, e_mfa, e_wfa, e_tmo;
  int          e_mrd, e_wrd;
  logic [31:0] e_busy;

  task automatic model_clear();
    for (int s = 0; s < 3; s++) begin
      mv[s] = 0; mrd[s] = 0; mwr[s] = 0; mld[s] = 0;
    end
    m_lu = 0; m_streak = 0; m_tflag = 0;
  endtask

  task automatic model_eval();
    e_freeze = mv[1] && mld[1] && !i_dmem_ack;
    e_lu     = i_id_valid && mv[0] && mld[0] && mwr[0] &&
               ((i_id_rs1_valid && int'(i_id_rs1_addr) == mrd[0]) ||
                (i_id_rs2_valid && int'(i_id_rs2_addr) == mrd[0]));
    e_bubble = e_lu && !e_freeze && !i_flush;
    e_stall  = (e_lu && !i_flush) || e_freeze;
    e_mrd    = mv[1] ? mrd[1] : 0;
    e_wrd    = mv[2] ? mrd[2] : 0;
    e_mfa    = mv[1] && mwr[1] && (!mld[1] || i_dmem_ack);
    e_wfa    = mv[2] && mwr[2];
    e_busy   = 32'd0;
    for (int s = 0; s < 3; s++)
      if (mv[s] && mwr[s]) e_busy = e_busy | (32'd1 << mrd[s]);
    e_tmo    = m_tflag || (e_freeze && (m_streak + 1 >= TMO));
  endtask

  task automatic model_advance();
    if (!e_freeze) begin
      mv[2] = mv[1]; mrd[2] = mrd[1]; mwr[2] = mwr[1]; mld[2] = mld[1];
      mv[1] = mv[0]; mrd[1] = mrd[0]; mwr[1] = mwr[0]; mld[1] = mld[0];
      if (i_flush || e_lu) begin
        mv[0] = 0; mrd[0] = 0; mwr[0] = 0; mld[0] = 0;
      end else begin
        mv[0]  = i_id_valid;
        mrd[0] = int'(i_id_rd_addr);
        mwr[0] = i_id_rd_wren && (i_id_rd_addr != 5'd0);
        mld[0] = i_id_is_load;
      end
    end
    if (e_bubble && m_lu < CNT_MAX) m_lu++;
    if (e_freeze) m_streak++;
    else m_streak = 0;
    if (m_streak >= TMO) m_tflag = 1;
  endtask

  // Called at posedge+1 with inputs driven; checks before the next edge.
  task automatic cycle();
    #1;
    model_eval();
    check("stall_id",     32'(o_stall_id),      32'(e_stall));
    check("bubble_ex",    32'(o_bubble_ex),     32'(e_bubble));
    check("freeze",       32'(o_freeze),        32'(e_freeze));
    check("mem_rd_addr",  32'(o_mem_rd_addr),   32'(e_mrd));
    check("mem_fwd",      32'(o_mem_fwd_allow), 32'(e_mfa));
    check("wb_rd_addr",   32'(o_wb_rd_addr),    32'(e_wrd));
    check("wb_fwd",       32'(o_wb_fwd_allow),  32'(e_wfa));
    check("busy_vec",     o_busy_vec,           e_busy);
    check("load_use_cnt", 32'(o_load_use_cnt),  32'(m_lu));
    check("dmem_timeout", 32'(o_dmem_timeout),  32'(e_tmo));
    @(posedge i_clk);
    model_advance();
    #1;
  endtask

  task automatic set_id(input bit v, input int rd, input bit wr, input bit ld,
                        input int rs1, input bit rs1v, input int rs2, input bit rs2v);
    i_id_valid     = v;
    i_id_rd_addr   = 5'(rd);
    i_id_rd_wren   = wr;
    i_id_is_load   = ld;
    i_id_rs1_addr  = 5'(rs1);
    i_id_rs1_valid = rs1v;
    i_id_rs2_addr  = 5'(rs2);
    i_id_rs2_valid = rs2v;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted between edges; outputs must drop at once.
  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    check("rst_stall",   32'(o_stall_id),      32'd0);
    check("rst_bubble",  32'(o_bubble_ex),     32'd0);
    check("rst_freeze",  32'(o_freeze),        32'd0);
    check("rst_mem_rd",  32'(o_mem_rd_addr),   32'd0);
    check("rst_mem_fwd", 32'(o_mem_fwd_allow), 32'd0);
    check("rst_wb_rd",   32'(o_wb_rd_addr),    32'd0);
    check("rst_wb_fwd",  32'(o_wb_fwd_allow),  32'd0);
    check("rst_busy",    o_busy_vec,           32'd0);
    check("rst_cnt",     32'(o_load_use_cnt),  32'd0);
    check("rst_tmo",     32'(o_dmem_timeout),  32'd0);
    model_clear();
    idle();
    i_flush    = 1'b0;
    i_dmem_ack = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_flush    = 1'b0;
    i_dmem_ack = 1'b1;
    idle();
    #2;
    do_reset();

    // Load-use with ack in the load's first MEM cycle: exactly one bubble.
    set_id(1, 5, 1, 1, 2, 1, 0, 0);            // lw x5
    cycle();
    set_id(1, 6, 1, 0, 5, 1, 1, 1);            // add x6,x5,x1
    #1;
    check("lu_stall",  32'(o_stall_id),  32'd1);
    check("lu_bubble", 32'(o_bubble_ex), 32'd1);
    cycle();
    #1;
    check("lu_stall_gone", 32'(o_stall_id),      32'd0);
    check("lu_mem_rd",     32'(o_mem_rd_addr),   32'd5);
    check("lu_mem_fwd",    32'(o_mem_fwd_allow), 32'd1);
    check("lu_cnt",        32'(o_load_use_cnt),  32'd1);
    cycle();

    // Memory wait: ack withheld three cycles.
    set_id(1, 9, 1, 1, 0, 0, 0, 0);            // lw x9
    cycle();
    idle();
    i_dmem_ack = 1'b0;
    cycle();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("mw_freeze",  32'(o_freeze),        32'd1);
      check("mw_mem_fwd", 32'(o_mem_fwd_allow), 32'd0);
      check("mw_mem_rd",  32'(o_mem_rd_addr),   32'd9);
      check("mw_wb_rd",   32'(o_wb_rd_addr),    32'd6);
      cycle();
    end
    i_dmem_ack = 1'b1;
    #1;
    check("mw_ack_freeze",  32'(o_freeze),        32'd0);
    check("mw_ack_mem_fwd", 32'(o_mem_fwd_allow), 32'd1);
    cycle();

    // Flush beats load-use.
    set_id(1, 7, 1, 1, 0, 0, 0, 0);            // lw x7
    cycle();
    set_id(1, 8, 1, 0, 3, 1, 7, 1);            // sub x8,x3,x7
    i_flush = 1'b1;
    #1;
    check("fl_bubble", 32'(o_bubble_ex), 32'd0);
    check("fl_stall",  32'(o_stall_id),  32'd0);
    cycle();
    i_flush = 1'b0;
    idle();
    #1;
    check("fl_cnt",    32'(o_load_use_cnt), 32'd1);
    check("fl_mem_rd", 32'(o_mem_rd_addr),  32'd7);
    check("fl_busy",   o_busy_vec,          32'h0000_0080);
    cycle();

    // x0 writes never appear busy or forwardable.
    set_id(1, 0, 1, 0, 0, 1, 0, 0);            // addi x0
    cycle();
    set_id(1, 3, 1, 0, 0, 1, 0, 0);            // addi x3
    #1;
    check("x0_busy0", 32'(o_busy_vec[0]), 32'd0);
    cycle();
    idle();
    #1;
    check("x0_busy_ex", o_busy_vec, 32'h0000_0008);
    cycle();
    #1;
    check("x0_busy_mem", o_busy_vec,           32'h0000_0008);
    check("x0_wb_fwd",   32'(o_wb_fwd_allow),  32'd0);
    check("x0_wb_rd",    32'(o_wb_rd_addr),    32'd0);
    cycle();
    #1;
    check("x0_busy_wb", o_busy_vec,          32'h0000_0008);
    check("x3_wb_fwd",  32'(o_wb_fwd_allow), 32'd1);
    check("x3_wb_rd",   32'(o_wb_rd_addr),   32'd3);
    cycle();
    #1;
    check("x3_busy_clear", o_busy_vec, 32'd0);
    cycle();

    // Timeout after four consecutive freeze cycles; sticky until reset.
    set_id(1, 4, 1, 1, 0, 0, 0, 0);            // lw x4
    cycle();
    idle();
    i_dmem_ack = 1'b0;
    #1;
    check("to_pre", 32'(o_dmem_timeout), 32'd0);
    cycle();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("to_freeze", 32'(o_freeze),       32'd1);
      check("to_flag",   32'(o_dmem_timeout), (k == 3) ? 32'd1 : 32'd0);
      cycle();
    end
    i_dmem_ack = 1'b1;
    #1;
    check("to_ack_freeze", 32'(o_freeze),       32'd0);
    check("to_ack_flag",   32'(o_dmem_timeout), 32'd1);
    cycle();
    for (int k = 0; k < 2; k++) begin
      #1;
      check("to_sticky", 32'(o_dmem_timeout), 32'd1);
      cycle();
    end

    // Mid-operation reset with a load-use pair in flight.
    set_id(1, 2, 1, 1, 0, 0, 0, 0);            // lw x2
    cycle();
    set_id(1, 10, 1, 0, 2, 1, 0, 0);           // consumer of x2
    cycle();
    do_reset();

    // Randomized traffic against the reference model, with one reset inside.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      set_id($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 4) != 0,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 1) == 1);
      i_flush    = ($urandom_range(0, 9) == 0);
      i_dmem_ack = ($urandom_range(0, 9) < 6);
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
